// File: rtl/vscale_dmem_responder.sv
// Data-memory responder for the vscale core's dmem port.
//
// Holds 2**ADDR_BITS 32-bit words and answers one load or store per access.
// Each access takes WAIT_CYCLES wait cycles followed by one completion
// (DONE) cycle.
//
// Parameters:
//   ADDR_BITS   - log2 of the number of 32-bit words stored.
//   WAIT_CYCLES - dmem_wait cycles inserted per access (0..15).
//
// Ports:
//   clk                - clock; all state changes on the rising edge.
//   reset              - asynchronous, active-high reset.
//   dmem_en            - request valid.
//   dmem_wen           - 1 = store, 0 = load.
//   dmem_size          - bits [1:0]: 0 byte, 1 half, 2 word (3 faults);
//                        bit 2 is ignored.
//   dmem_addr          - byte address.
//   dmem_wdata_delayed - lane-replicated store data, valid in the completion
//                        cycle.
//   dmem_rdata         - aligned full word read.
//   dmem_wait          - response not yet complete.
//   dmem_badmem_e      - access fault, valid in the completion cycle.
//
// All outputs come straight from registers.
module vscale_dmem_responder #(
   parameter int unsigned ADDR_BITS   = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dmem_en,
   input  logic        dmem_wen,
   input  logic [2:0]  dmem_size,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata_delayed,
   output logic [31:0] dmem_rdata,
   output logic        dmem_wait,
   output logic        dmem_badmem_e
);

   localparam int unsigned Words = 1 << ADDR_BITS;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   wen_q, wen_d;
   logic                   fault_q, fault_d;
   logic [ADDR_BITS-1:0]   idx_q, idx_d;
   logic [3:0]             lanes_q, lanes_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   wait_q, wait_d;
   logic                   badmem_q, badmem_d;

   logic [31:0]            mem [Words];

   logic                   accept;
   logic                   commit;
   logic [ADDR_BITS-1:0]   req_idx;
   logic                   req_fault;
   logic [3:0]             req_lanes;
   logic [31:0]            addr_hi;
   logic [31:0]            merged;
   logic [31:0]            read_word;

   // Request decode.
   always_comb begin
      accept  = dmem_en && (state_q == StIdle || state_q == StDone);
      req_idx = dmem_addr[ADDR_BITS+1:2];
      addr_hi = dmem_addr >> (ADDR_BITS + 2);

      req_fault = (addr_hi != 32'd0)
                  || (dmem_size[1:0] == 2'd3)
                  || (dmem_size[1:0] == 2'd1 && dmem_addr[0])
                  || (dmem_size[1:0] == 2'd2 && dmem_addr[1:0] != 2'd0);

      req_lanes = 4'b1111;
      case (dmem_size[1:0])
         2'd0:    req_lanes = 4'b0001 << dmem_addr[1:0];
         2'd1:    req_lanes = dmem_addr[1] ? 4'b1100 : 4'b0011;
         default: req_lanes = 4'b1111;
      endcase
   end

   // The pending store is written on the edge that ends its DONE cycle. A
   // load accepted on that same edge sees the merged word.
   always_comb begin
      commit = (state_q == StDone) && wen_q && !fault_q;
      merged = mem[idx_q];
      for (int b = 0; b < 4; b++) begin
         if (lanes_q[b]) begin
            merged[8*b +: 8] = dmem_wdata_delayed[8*b +: 8];
         end
      end
      read_word = (commit && idx_q == req_idx) ? merged : mem[req_idx];
   end

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wen_d    = wen_q;
      fault_d  = fault_q;
      idx_d    = idx_q;
      lanes_d  = lanes_q;
      rdata_d  = rdata_q;
      badmem_d = badmem_q;

      unique case (state_q)
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            if (!accept) begin
               state_d = StIdle;
            end
         end
         default: ;
      endcase

      if (accept) begin
         wen_d    = dmem_wen;
         fault_d  = req_fault;
         idx_d    = req_idx;
         lanes_d  = req_lanes;
         badmem_d = req_fault;
         // Store rdata is don't-care; faulting loads return zero.
         rdata_d  = (dmem_wen || req_fault) ? 32'd0 : read_word;
         if (WAIT_CYCLES == 0) begin
            state_d = StDone;
            cnt_d   = 4'd0;
         end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
         end
      end

      wait_d = (state_d == StWait);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         wen_q    <= 1'b0;
         fault_q  <= 1'b0;
         idx_q    <= '0;
         lanes_q  <= 4'd0;
         rdata_q  <= 32'd0;
         wait_q   <= 1'b0;
         badmem_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wen_q    <= wen_d;
         fault_q  <= fault_d;
         idx_q    <= idx_d;
         lanes_q  <= lanes_d;
         rdata_q  <= rdata_d;
         wait_q   <= wait_d;
         badmem_q <= badmem_d;
      end
   end

   // Storage is never cleared. Reset forces state_q to IDLE, which kills
   // commit, so a store interrupted by reset never writes.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (lanes_q[b]) begin
               mem[idx_q][8*b +: 8] <= dmem_wdata_delayed[8*b +: 8];
            end
         end
      end
   end

   assign dmem_rdata    = rdata_q;
   assign dmem_wait     = wait_q;
   assign dmem_badmem_e = badmem_q;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: five instances with
// WAIT_CYCLES 0, 1, 2, 3 and 5, each with its own reference memory and a
// scoreboard of expected responses.
module tb_vscale_dmem_responder;

   localparam int NDUT = 5;
   localparam int unsigned WAITS [NDUT] = '{0, 1, 2, 3, 5};

   logic        clk;
   logic        rst   [NDUT];
   logic        en    [NDUT];
   logic        wen   [NDUT];
   logic [2:0]  size  [NDUT];
   logic [31:0] addr  [NDUT];
   logic [31:0] wdata [NDUT];
   logic [31:0] rdata [NDUT];
   logic        waitv [NDUT];
   logic        bad   [NDUT];

   int n_cmp;
   int n_bad;

   typedef struct {
      bit          w;
      bit          bad;
      logic [31:0] rd;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mdl [NDUT][1024];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      vscale_dmem_responder #(
         .ADDR_BITS  (10),
         .WAIT_CYCLES(WAITS[g])
      ) u_dut (
         .clk               (clk),
         .reset             (rst[g]),
         .dmem_en           (en[g]),
         .dmem_wen          (wen[g]),
         .dmem_size         (size[g]),
         .dmem_addr         (addr[g]),
         .dmem_wdata_delayed(wdata[g]),
         .dmem_rdata        (rdata[g]),
         .dmem_wait         (waitv[g]),
         .dmem_badmem_e     (bad[g])
      );
   end

   function automatic bit m_fault(logic [2:0] sz, logic [31:0] a);
      return (a[31:12] != 0) || (sz[1:0] == 2'd3)
             || (sz[1:0] == 2'd1 && a[0]) || (sz[1:0] == 2'd2 && a[1:0] != 0);
   endfunction

   // Drive one access starting at #1 after a rising edge; returns during its
   // completion cycle, so a following call is accepted back-to-back.
   task automatic do_access(int k, bit w, logic [2:0] sz, logic [31:0] a,
                            logic [31:0] d);
      exp_t        e;
      exp_t        got;
      int          n;
      logic [31:0] word;
      int          wi;
      en[k] = 1'b1; wen[k] = w; size[k] = sz; addr[k] = a;
      wi = int'(a[11:2]);
      e.w   = w;
      e.bad = m_fault(sz, a);
      e.rd  = 32'd0;
      if (!e.bad) begin
         if (w) begin
            word = mdl[k][wi];
            case (sz[1:0])
               2'd0: word[8*a[1:0] +: 8] = d[8*a[1:0] +: 8];
               2'd1: word[16*a[1] +: 16] = d[16*a[1] +: 16];
               default: word = d;
            endcase
            mdl[k][wi] = word;
         end else begin
            e.rd = mdl[k][wi];
         end
      end
      sb.push_back(e);
      @(posedge clk); #1;
      en[k] = 1'b0;
      wdata[k] = d;
      n = 0;
      while (waitv[k] === 1'b1 && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      got = sb.pop_front();
      n_cmp++;
      if (n !== int'(WAITS[k])) begin
         n_bad++;
         $display("FAIL wait_cycles dut%0d addr=%h: got %0d, want %0d", k, a, n, WAITS[k]);
      end
      n_cmp++;
      if (bad[k] !== got.bad) begin
         n_bad++;
         $display("FAIL badmem dut%0d addr=%h size=%0d: got %b, want %b",
                  k, a, sz, bad[k], got.bad);
      end
      if (!got.w) begin
         n_cmp++;
         if (rdata[k] !== got.rd) begin
            n_bad++;
            $display("FAIL rdata dut%0d addr=%h size=%0d: got %h, want %h",
                     k, a, sz, rdata[k], got.rd);
         end
      end
   endtask

   task automatic idle(int k, int n);
      en[k] = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < NDUT; k++) begin
         rst[k] = 1'b1; en[k] = 1'b0; wen[k] = 1'b0; size[k] = 3'd0;
         addr[k] = 32'd0; wdata[k] = 32'd0;
      end
      #2;
      for (int k = 0; k < NDUT; k++) begin
         n_cmp++;
         if (rdata[k] !== 32'd0 || waitv[k] !== 1'b0 || bad[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: got rdata=%h wait=%b bad=%b, want 0/0/0",
                     k, rdata[k], waitv[k], bad[k]);
         end
      end
      @(posedge clk); @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
   endtask

   task automatic test_forward();
      do_access(0, 1'b1, 3'd2, 32'h40, 32'h1234_5678);
      do_access(0, 1'b0, 3'd2, 32'h40, 32'h0);
      idle(0, 1);
   endtask

   task automatic test_lanes();
      do_access(0, 1'b1, 3'd0, 32'h41, 32'hAAAA_AAAA);
      do_access(0, 1'b0, 3'd2, 32'h40, 32'h0);
      do_access(0, 1'b1, 3'd1, 32'h42, 32'hBEEF_BEEF);
      do_access(0, 1'b0, 3'd2, 32'h40, 32'h0);
      idle(0, 2);
      do_access(0, 1'b0, 3'd6, 32'h40, 32'h0);
      idle(0, 1);
      do_access(0, 1'b0, 3'd2, 32'h40, 32'h0);
      idle(0, 1);
   endtask

   task automatic test_wait();
      do_access(3, 1'b1, 3'd2, 32'h10, 32'h0BAD_F00D);
      do_access(3, 1'b0, 3'd2, 32'h10, 32'h0);
      idle(3, 1);
   endtask

   task automatic test_faults();
      for (int k = 0; k < NDUT; k += 3) begin
         do_access(k, 1'b1, 3'd2, 32'h0, 32'h5555_0000);
         do_access(k, 1'b1, 3'd2, 32'h40, 32'hCAFE_1234);
         do_access(k, 1'b0, 3'd2, 32'h42, 32'h0);
         do_access(k, 1'b1, 3'd1, 32'h43, 32'hFFFF_FFFF);
         do_access(k, 1'b1, 3'd2, 32'h1000, 32'hDEAD_BEEF);
         do_access(k, 1'b1, 3'd3, 32'h40, 32'h0F0F_0F0F);
         do_access(k, 1'b0, 3'd2, 32'h40, 32'h0);
         idle(k, 1);
         do_access(k, 1'b0, 3'd2, 32'h0, 32'h0);
         idle(k, 1);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      k = 2;
      do_access(k, 1'b1, 3'd2, 32'h80, 32'h1111_1111);
      idle(k, 1);
      en[k] = 1'b1; wen[k] = 1'b1; size[k] = 3'd2; addr[k] = 32'h80;
      @(posedge clk); #1;
      wdata[k] = 32'hFFFF_FFFF;
      en[k] = 1'b0;
      n_cmp++;
      if (waitv[k] !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_accept_wait: got %b, want 1", waitv[k]);
      end
      #2 rst[k] = 1'b1;
      #1;
      n_cmp++;
      if (waitv[k] !== 1'b0 || bad[k] !== 1'b0 || rdata[k] !== 32'd0) begin
         n_bad++;
         $display("FAIL async_reset: got wait=%b bad=%b rdata=%h, want 0/0/0",
                  waitv[k], bad[k], rdata[k]);
      end
      en[k] = 1'b1; wen[k] = 1'b0; addr[k] = 32'h80;
      @(posedge clk); #1;
      n_cmp++;
      if (waitv[k] !== 1'b0) begin
         n_bad++;
         $display("FAIL ignore_in_reset: got wait=%b, want 0", waitv[k]);
      end
      rst[k] = 1'b0;
      do_access(k, 1'b0, 3'd2, 32'h80, 32'h0);
      idle(k, 1);
   endtask

   task automatic test_random();
      int ks [3] = '{0, 1, 4};
      for (int j = 0; j < 3; j++) begin
         int k;
         k = ks[j];
         for (int i = 0; i < 16; i++) begin
            do_access(k, 1'b1, 3'd2, 32'(i * 4), $urandom);
         end
         for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = a | 32'h0000_1000;
            do_access(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(1, 2));
         end
         idle(k, 1);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_forward();
      test_lanes();
      test_wait();
      test_faults();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
